// File: rtl/clb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clb_pkg
//  Description : Shared types and helpers for the calibration block offset
//                calibration sequencer (state encoding, DTO sample type,
//                saturating negate).
//  Revision    : 1.0 - initial release
// ============================================================================
package clb_pkg;

  localparam int DTO_W = 16;

  // One raw ADC sample as carried on the DTO tap
  typedef logic signed [DTO_W-1:0] dto_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_CALC   = 3'd3,
    ST_APPLY  = 3'd4
  } state_t;

  // Returns -v clamped to the signed range of a dw-bit word.
  // Works on a 64-bit container so callers with any mean width up to 63 bits
  // can share it; the caller keeps the low dw bits.
  function automatic logic signed [63:0] sat_neg(input logic signed [63:0] v,
                                                 input int dw);
    logic signed [63:0] n;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    n  = -v;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (n > hi) return hi;
    if (n < lo) return lo;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clb_ofs_cal_if.sv
`default_nettype none
// ============================================================================
//  Module      : clb_ofs_cal_if
//  Description : Raw ADC tap bundle (all channels) observed by the offset
//                calibration sequencer.
//                master : stream source side (drives everything)
//                slave  : monitor side (observes everything)
//  Ports       : sti_tdata  MNO*DW  channel i at [i*DW +: DW]
//                sti_tvalid MNO     per-channel valid
//                sti_tready MNO     per-channel ready (transfer = valid&ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface clb_ofs_cal_if #(
  parameter int DW  = 16,
  parameter int MNO = 2
);
  logic [MNO*DW-1:0] sti_tdata;
  logic [MNO-1:0]    sti_tvalid;
  logic [MNO-1:0]    sti_tready;

  modport master (output sti_tdata, output sti_tvalid, output sti_tready);
  modport slave  (input  sti_tdata, input  sti_tvalid, input  sti_tready);
endinterface
`default_nettype wire

// File: rtl/clb_ofs_acc.sv
`default_nettype none
// ============================================================================
//  Module      : clb_ofs_acc
//  Description : Signed sample accumulator with transfer counter. o_tc flags
//                the enabled beat that completes 2^i_log2n accumulations.
//  Ports       : clk, rstn        clock / async active-low reset
//                i_clr            clear accumulator and counter
//                i_en             accumulate i_data this cycle
//                i_data   DW      signed sample
//                i_log2n  5       log2 of accumulation length (<= LMAX)
//                o_acc    DW+LMAX accumulator value
//                o_tc     1       terminal-count beat (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module clb_ofs_acc #(
  parameter int DW   = 16,
  parameter int LMAX = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic signed [DW-1:0]        i_data,
  input  logic [4:0]                  i_log2n,
  output logic signed [DW+LMAX-1:0]   o_acc,
  output logic                        o_tc
);

  localparam int AW = DW + LMAX;
  localparam int CW = LMAX + 1;
  localparam logic [CW-1:0] c_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_last;

  // Index of the final beat: 2^log2n - 1
  assign w_last = (c_ONE << i_log2n) - c_ONE;
  assign o_tc   = i_en && (r_cnt == w_last);
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + {{LMAX{i_data[DW-1]}}, i_data};
      r_cnt <= r_cnt + c_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clb_ofs_cal.sv
`default_nettype none
// ============================================================================
//  Module      : clb_ofs_cal
//  Description : Automatic ADC offset calibration sequencer. Selects one raw
//                ADC stream, discards settle transfers, averages 2^N
//                transfers and writes the negated, saturated, rounded mean
//                as that channel's cfg_adc_sum through a one-cycle strobe.
//  Ports       : clk, rstn          clock / async active-low reset
//                ctl_start/abort    control pulses (abort has priority)
//                cfg_chn/log2n/settle  configuration, latched on start
//                sti                raw ADC tap (slave modport)
//                cfg_sum/idx/we     offset write port
//                sts_busy/done/err  status (done/err sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module clb_ofs_cal #(
  parameter int DW   = 16,
  parameter int MNO  = 2,
  parameter int LMAX = 16,
  parameter int SW   = 16,
  parameter int TW   = 20
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ctl_start,
  input  logic                     ctl_abort,
  input  logic [$clog2(MNO)-1:0]   cfg_chn,
  input  logic [4:0]               cfg_log2n,
  input  logic [SW-1:0]            cfg_settle,
  clb_ofs_cal_if.slave             sti,
  output logic [DW-1:0]            cfg_sum,
  output logic [$clog2(MNO)-1:0]   cfg_sum_idx,
  output logic                     cfg_sum_we,
  output logic                     sts_busy,
  output logic                     sts_done,
  output logic                     sts_err
);
  import clb_pkg::*;

  localparam int AW = DW + LMAX;
  localparam logic [4:0]    c_LMAX    = 5'(LMAX);
  localparam logic [SW-1:0] c_SET_ONE = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] c_TO_ONE  = {{(TW-1){1'b0}}, 1'b1};
  // Timeout fires on the idle cycle that would bring the counter to 2^TW-1
  localparam logic [TW-1:0] c_TO_LAST = {{(TW-1){1'b1}}, 1'b0};

  state_t                   r_state;
  logic [$clog2(MNO)-1:0]   r_chn;
  logic [4:0]               r_log2n;
  logic [SW-1:0]            r_settle;
  logic [SW-1:0]            r_set_cnt;
  logic [TW-1:0]            r_to;
  logic [DW-1:0]            r_sum;
  logic [$clog2(MNO)-1:0]   r_idx;
  logic                     r_we;
  logic                     r_done;
  logic                     r_err;

  logic                     w_xfer;
  logic signed [DW-1:0]     w_data;
  logic [4:0]               w_log2n_cl;
  logic                     w_acc_clr;
  logic                     w_acc_en;
  logic                     w_tc;
  logic signed [AW-1:0]     w_acc;
  logic [AW:0]              w_half;
  logic signed [AW:0]       w_round;
  logic signed [AW:0]       w_mean;
  logic signed [63:0]       w_ofs;
  logic                     w_unused_ofs;

  // Channel mux on the latched channel only
  assign w_xfer = sti.sti_tvalid[r_chn] & sti.sti_tready[r_chn];
  assign w_data = sti.sti_tdata[int'(r_chn)*DW +: DW];

  assign w_log2n_cl = (cfg_log2n > c_LMAX) ? c_LMAX : cfg_log2n;

  assign w_acc_clr = (r_state == ST_IDLE) && ctl_start && !ctl_abort;
  assign w_acc_en  = (r_state == ST_ACCUM) && w_xfer && !ctl_abort;

  clb_ofs_acc #(
    .DW   (DW),
    .LMAX (LMAX)
  ) u_acc (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_acc_clr),
    .i_en    (w_acc_en),
    .i_data  (w_data),
    .i_log2n (r_log2n),
    .o_acc   (w_acc),
    .o_tc    (w_tc)
  );

  // Round half up: add 2^(log2n-1) (zero when log2n==0), then arithmetic
  // shift. One guard bit keeps the biased sum from wrapping.
  assign w_half  = ({{AW{1'b0}}, 1'b1} << r_log2n) >> 1;
  assign w_round = $signed({w_acc[AW-1], w_acc}) + $signed(w_half);
  assign w_mean  = w_round >>> r_log2n;
  assign w_ofs   = sat_neg({{(63-AW){w_mean[AW]}}, w_mean}, DW);
  // Upper bits are redundant after saturation to DW bits
  assign w_unused_ofs = ^w_ofs[63:DW];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_chn     <= '0;
      r_log2n   <= '0;
      r_settle  <= '0;
      r_set_cnt <= '0;
      r_to      <= '0;
      r_sum     <= '0;
      r_idx     <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (ctl_abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (ctl_start) begin
              r_chn     <= cfg_chn;
              r_log2n   <= w_log2n_cl;
              r_settle  <= cfg_settle;
              r_set_cnt <= '0;
              r_to      <= '0;
              r_done    <= 1'b0;
              r_err     <= 1'b0;
              // Nothing to discard: the first cycle after start already accumulates
              r_state   <= (cfg_settle == '0) ? ST_ACCUM : ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (w_xfer) begin
              r_to      <= '0;
              r_set_cnt <= r_set_cnt + c_SET_ONE;
              if (r_set_cnt == r_settle - c_SET_ONE) r_state <= ST_ACCUM;
            end else if (r_to == c_TO_LAST) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_to <= r_to + c_TO_ONE;
            end
          end
          ST_ACCUM: begin
            if (w_xfer) begin
              r_to <= '0;
              if (w_tc) r_state <= ST_CALC;
            end else if (r_to == c_TO_LAST) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_to <= r_to + c_TO_ONE;
            end
          end
          ST_CALC: begin
            // Registered here so the strobe and done are visible during APPLY
            r_sum   <= w_ofs[DW-1:0];
            r_idx   <= r_chn;
            r_we    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_APPLY;
          end
          ST_APPLY: begin
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cfg_sum     = r_sum;
  assign cfg_sum_idx = r_idx;
  assign cfg_sum_we  = r_we;
  assign sts_busy    = (r_state != ST_IDLE);
  assign sts_done    = r_done;
  assign sts_err     = r_err;

endmodule
`default_nettype wire
